// File: rtl/lpc_capture_ctrl_if.sv
// Decoded-cycle input bus and outgoing byte stream of lpc_capture_ctrl.
// master = capture controller side, slave = decoder/UART side.
interface lpc_capture_ctrl_if;
  logic [3:0]  in_cyctype_dir;
  logic [31:0] in_addr;
  logic [7:0]  in_data;
  logic        in_clock_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    input  in_cyctype_dir, in_addr, in_data, in_clock_enable, tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output in_cyctype_dir, in_addr, in_data, in_clock_enable, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/lpc_capture_ctrl.sv
// Captures address-filtered LPC cycles into a FIFO and drains them as byte frames.
// Define LPC_CAPTURE_TIMESTAMP_EN to append a 16-bit capture timestamp to each frame.
module lpc_capture_ctrl #(
  parameter int         DEPTH  = 16,
  parameter logic [7:0] MARKER = 8'hA5
) (
  input  logic                   lpc_clock,
  input  logic                   lpc_reset,
  input  logic                   enable,
  input  logic [31:0]            cfg_base,
  input  logic [31:0]            cfg_mask,
  lpc_capture_ctrl_if.master     lpc_bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
`ifdef LPC_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W   = 60;
  localparam int FRAME_LEN = 9;
`else
  localparam int ENTRY_W   = 44;
  localparam int FRAME_LEN = 7;
`endif
  localparam int            IW   = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              state_reg, state_next;
  logic                ce_q_reg;
  logic                cap, hit, full, push, drop, load;
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  entry;
  logic [ENTRY_W-1:0]  frame_reg;
  logic                ovf_reg, frame_ovf_reg;
  logic [7:0]          drop_count_reg;
  logic [IW-1:0]       idx_reg, idx_next, idx_inc;
  logic                tx_valid_reg, tx_valid_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic [7:0]          frame_bytes [FRAME_LEN];

  assign cap  = lpc_bus.in_clock_enable & ~ce_q_reg;
  assign hit  = enable & cap & (((lpc_bus.in_addr ^ cfg_base) & cfg_mask) == 32'h0);
  // Full is judged on the pre-pop level, so a same-cycle pop never makes room.
  assign full = (fifo_level == PW'(DEPTH));
  assign push = hit & ~full;
  assign drop = hit & full;

`ifdef LPC_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_reg;

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      ts_reg <= 16'h0;
    end else begin
      ts_reg <= ts_reg + 16'd1;
    end
  end

  assign entry = {ts_reg, lpc_bus.in_cyctype_dir, lpc_bus.in_addr, lpc_bus.in_data};
`else
  assign entry = {lpc_bus.in_cyctype_dir, lpc_bus.in_addr, lpc_bus.in_data};
`endif

  // Storage array and its registered read port; the read lands directly in the frame register.
  always_ff @(posedge lpc_clock) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= entry;
    end
    if (load) begin
      frame_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign frame_bytes[0] = MARKER;
  assign frame_bytes[1] = {frame_reg[43:40], frame_ovf_reg, 3'b000};
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_addr_bytes
      assign frame_bytes[2+gi] = frame_reg[39-8*gi -: 8];
    end
  endgenerate
  assign frame_bytes[6] = frame_reg[7:0];
`ifdef LPC_CAPTURE_TIMESTAMP_EN
  assign frame_bytes[7] = frame_reg[59:52];
  assign frame_bytes[8] = frame_reg[51:44];
`endif

  assign idx_inc = idx_reg + IW'(1);

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    load          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (fifo_level != '0) begin
          load          = 1'b1;
          state_next    = S_SEND;
          idx_next      = '0;
          tx_valid_next = 1'b1;
          tx_data_next  = MARKER;
        end
      end
      S_SEND: begin
        if (lpc_bus.tx_ready) begin
          if (idx_reg == LAST) begin
            state_next    = S_IDLE;
            tx_valid_next = 1'b0;
          end else begin
            idx_next     = idx_inc;
            tx_data_next = frame_bytes[idx_inc];
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      ce_q_reg       <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      ovf_reg        <= 1'b0;
      frame_ovf_reg  <= 1'b0;
      drop_count_reg <= 8'h0;
      state_reg      <= S_IDLE;
      idx_reg        <= '0;
      tx_valid_reg   <= 1'b0;
      tx_data_reg    <= 8'h0;
    end else begin
      ce_q_reg <= lpc_bus.in_clock_enable;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (load) begin
        rd_ptr_reg    <= rd_ptr_reg + PW'(1);
        frame_ovf_reg <= ovf_reg;
      end
      // A drop coinciding with a load survives into the following frame.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (load) begin
        ovf_reg <= 1'b0;
      end
      if (drop && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  assign fifo_level       = wr_ptr_reg - rd_ptr_reg;
  assign drop_count       = drop_count_reg;
  assign busy             = (fifo_level != '0) | (state_reg != S_IDLE);
  assign lpc_bus.tx_valid = tx_valid_reg;
  assign lpc_bus.tx_data  = tx_data_reg;

endmodule
